// File: rtl/sa_read_channel.sv
// Slave-side AXI4 read arbiter: round-robin AR grant into a registered AR stage,
// with an order FIFO that routes R bursts back to masters. Optional RID check: SA_RID_CHECK_EN.
module sa_read_channel #(
    parameter int MST_AMT           = 2,
    parameter int OUTSTANDING_AMT   = 8,
    parameter int DATA_WIDTH        = 32,
    parameter int ADDR_WIDTH        = 32,
    parameter int TRANS_MST_ID_W    = 5,
    parameter int TRANS_BURST_W     = 2,
    parameter int TRANS_DATA_LEN_W  = 3,
    parameter int TRANS_DATA_SIZE_W = 3
) (
    input  logic                                   ACLK_i,
    input  logic                                   ARESET_i,
    input  logic [MST_AMT*TRANS_MST_ID_W-1:0]      dsp_ARID_i,
    input  logic [MST_AMT*ADDR_WIDTH-1:0]          dsp_ARADDR_i,
    input  logic [MST_AMT*TRANS_BURST_W-1:0]       dsp_ARBURST_i,
    input  logic [MST_AMT*TRANS_DATA_LEN_W-1:0]    dsp_ARLEN_i,
    input  logic [MST_AMT*TRANS_DATA_SIZE_W-1:0]   dsp_ARSIZE_i,
    input  logic [MST_AMT-1:0]                     dsp_ARVALID_i,
    output logic [MST_AMT-1:0]                     dsp_ARREADY_o,
    output logic [TRANS_MST_ID_W-1:0]              dsp_RID_o,
    output logic [DATA_WIDTH-1:0]                  dsp_RDATA_o,
    output logic                                   dsp_RLAST_o,
    output logic [MST_AMT-1:0]                     dsp_RVALID_o,
    input  logic [MST_AMT-1:0]                     dsp_RREADY_i,
    output logic [TRANS_MST_ID_W-1:0]              s_ARID_o,
    output logic [ADDR_WIDTH-1:0]                  s_ARADDR_o,
    output logic [TRANS_BURST_W-1:0]               s_ARBURST_o,
    output logic [TRANS_DATA_LEN_W-1:0]            s_ARLEN_o,
    output logic [TRANS_DATA_SIZE_W-1:0]           s_ARSIZE_o,
    output logic                                   s_ARVALID_o,
    input  logic                                   s_ARREADY_i,
    input  logic [TRANS_MST_ID_W-1:0]              s_RID_i,
    input  logic [DATA_WIDTH-1:0]                  s_RDATA_i,
    input  logic                                   s_RLAST_i,
    input  logic                                   s_RVALID_i,
    output logic                                   s_RREADY_o,
    output logic                                   rid_err_o
);

    localparam int IDX_W = (MST_AMT > 1) ? $clog2(MST_AMT) : 1;
    localparam int AW    = $clog2(OUTSTANDING_AMT);
    localparam int PTR_W = AW + 1;

    logic [IDX_W-1:0] prio, grant_idx, head;
    logic [IDX_W:0]   cand;
    logic             any_req, accept, ar_free, full, empty, r_hs, pop;
    logic [PTR_W-1:0] wptr, rptr;
    logic [IDX_W-1:0] fifo_mst [OUTSTANDING_AMT];

    // First requester at or after prio, searching upward with wrap.
    always_comb begin
        any_req   = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int i = 0; i < MST_AMT; i++) begin
            cand = {1'b0, prio} + (IDX_W+1)'(i);
            if (cand >= (IDX_W+1)'(MST_AMT))
                cand = cand - (IDX_W+1)'(MST_AMT);
            if (!any_req && dsp_ARVALID_i[cand[IDX_W-1:0]]) begin
                any_req   = 1'b1;
                grant_idx = cand[IDX_W-1:0];
            end
        end
    end

    assign ar_free = ~s_ARVALID_o | s_ARREADY_i;
    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    // Full blocks the grant even if a pop lands in the same cycle.
    assign accept  = any_req & ar_free & ~full & ~ARESET_i;
    assign head    = fifo_mst[rptr[AW-1:0]];

    assign s_RREADY_o  = ~empty & dsp_RREADY_i[head];
    assign r_hs        = s_RVALID_i & s_RREADY_o;
    assign pop         = r_hs & s_RLAST_i;
    assign dsp_RID_o   = s_RID_i;
    assign dsp_RDATA_o = s_RDATA_i;
    assign dsp_RLAST_o = s_RLAST_i;

    for (genvar m = 0; m < MST_AMT; m++) begin : g_lane
        assign dsp_ARREADY_o[m] = accept & (grant_idx == IDX_W'(m));
        assign dsp_RVALID_o[m]  = s_RVALID_i & ~empty & (head == IDX_W'(m));
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            s_ARVALID_o <= 1'b0;
            s_ARID_o    <= '0;
            s_ARADDR_o  <= '0;
            s_ARBURST_o <= '0;
            s_ARLEN_o   <= '0;
            s_ARSIZE_o  <= '0;
            prio        <= '0;
        end else if (accept) begin
            s_ARVALID_o <= 1'b1;
            s_ARID_o    <= dsp_ARID_i[grant_idx*TRANS_MST_ID_W +: TRANS_MST_ID_W];
            s_ARADDR_o  <= dsp_ARADDR_i[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            s_ARBURST_o <= dsp_ARBURST_i[grant_idx*TRANS_BURST_W +: TRANS_BURST_W];
            s_ARLEN_o   <= dsp_ARLEN_i[grant_idx*TRANS_DATA_LEN_W +: TRANS_DATA_LEN_W];
            s_ARSIZE_o  <= dsp_ARSIZE_i[grant_idx*TRANS_DATA_SIZE_W +: TRANS_DATA_SIZE_W];
            prio        <= (grant_idx == IDX_W'(MST_AMT-1)) ? '0 : grant_idx + 1'b1;
        end else if (s_ARREADY_i) begin
            s_ARVALID_o <= 1'b0;
        end
    end

    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge ACLK_i) begin
        if (accept) fifo_mst[wptr[AW-1:0]] <= grant_idx;
    end

`ifdef SA_RID_CHECK_EN
    logic [TRANS_MST_ID_W-1:0] fifo_id [OUTSTANDING_AMT];

    always_ff @(posedge ACLK_i) begin
        if (accept) fifo_id[wptr[AW-1:0]] <= dsp_ARID_i[grant_idx*TRANS_MST_ID_W +: TRANS_MST_ID_W];
    end

    // Sticky until reset; routing never depends on it.
    always_ff @(posedge ACLK_i or posedge ARESET_i) begin
        if (ARESET_i)
            rid_err_o <= 1'b0;
        else if (r_hs && (s_RID_i != fifo_id[rptr[AW-1:0]]))
            rid_err_o <= 1'b1;
    end
`else
    assign rid_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sa_read_channel.sv
// Self-checking bench for sa_read_channel: directed scenarios plus a random phase,
// checked against a queue-based transaction model.
module tb_sa_read_channel;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  ar_id;
    logic [63:0] ar_addr;
    logic [3:0]  ar_burst;
    logic [5:0]  ar_len;
    logic [5:0]  ar_size;
    logic [1:0]  ar_vld;
    logic [1:0]  ar_rdy;
    logic [4:0]  d_rid;
    logic [31:0] d_rdata;
    logic        d_rlast;
    logic [1:0]  d_rvalid;
    logic [1:0]  r_rdy;
    logic [4:0]  s_arid;
    logic [31:0] s_araddr;
    logic [1:0]  s_arburst;
    logic [2:0]  s_arlen, s_arsize;
    logic        s_arvalid, s_arready;
    logic [4:0]  s_rid;
    logic [31:0] s_rdata;
    logic        s_rlast, s_rvalid, s_rready, rid_err;

    sa_read_channel dut (
        .ACLK_i(clk), .ARESET_i(rst),
        .dsp_ARID_i(ar_id), .dsp_ARADDR_i(ar_addr), .dsp_ARBURST_i(ar_burst),
        .dsp_ARLEN_i(ar_len), .dsp_ARSIZE_i(ar_size), .dsp_ARVALID_i(ar_vld),
        .dsp_ARREADY_o(ar_rdy),
        .dsp_RID_o(d_rid), .dsp_RDATA_o(d_rdata), .dsp_RLAST_o(d_rlast),
        .dsp_RVALID_o(d_rvalid), .dsp_RREADY_i(r_rdy),
        .s_ARID_o(s_arid), .s_ARADDR_o(s_araddr), .s_ARBURST_o(s_arburst),
        .s_ARLEN_o(s_arlen), .s_ARSIZE_o(s_arsize), .s_ARVALID_o(s_arvalid),
        .s_ARREADY_i(s_arready),
        .s_RID_i(s_rid), .s_RDATA_i(s_rdata), .s_RLAST_i(s_rlast), .s_RVALID_i(s_rvalid),
        .s_RREADY_o(s_rready), .rid_err_o(rid_err)
    );

    always #5 clk = ~clk;

    typedef struct { int mst; logic [4:0] id; } ent_t;

    // Transaction-level model: one AR holding slot plus an ordered list of outstanding bursts.
    ent_t        oq[$];
    logic        m_arvld, m_rid_err;
    logic [4:0]  m_id;
    logic [31:0] m_addr;
    logic [2:0]  m_len;
    int          m_prio;

    int checks = 0, errors = 0;
    logic [1:0] last_ar, last_rv;
    logic       last_rr;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        oq.delete();
        m_arvld = 0; m_rid_err = 0; m_id = 0; m_addr = 0; m_len = 0; m_prio = 0;
    endtask

    task automatic clear_inputs();
        ar_id = '0; ar_addr = '0; ar_burst = '0; ar_len = '0; ar_size = '0; ar_vld = '0;
        r_rdy = '0; s_arready = 0; s_rid = '0; s_rdata = '0; s_rlast = 0; s_rvalid = 0;
    endtask

    task automatic set_req(input int m, input logic v, input logic [4:0] id,
                           input logic [31:0] addr, input logic [2:0] len);
        ar_vld[m] = v;
        ar_id[m*5 +: 5] = id;
        ar_addr[m*32 +: 32] = addr;
        ar_len[m*3 +: 3] = len;
        ar_burst[m*2 +: 2] = 2'b01;
        ar_size[m*3 +: 3] = 3'd2;
    endtask

    // Called just after a rising edge with inputs set; checks mid-cycle, advances the model.
    task automatic step();
        int g, h;
        logic acc, hs;
        logic [1:0] e_ar, e_rv;
        logic e_rr;
        @(negedge clk);
        g = -1;
        for (int i = 0; i < 2; i++)
            if (g < 0 && ar_vld[(m_prio + i) % 2]) g = (m_prio + i) % 2;
        acc  = (g >= 0) && (!m_arvld || s_arready) && (oq.size() < 8);
        e_ar = acc ? 2'(1 << g) : 2'b00;
        e_rv = 2'b00; e_rr = 0; h = 0;
        if (oq.size() > 0) begin
            h    = oq[0].mst;
            e_rv = s_rvalid ? 2'(1 << h) : 2'b00;
            e_rr = r_rdy[h];
        end
        hs = s_rvalid && e_rr;
        chk("arready", ar_rdy, e_ar);
        chk("rvalid", d_rvalid, e_rv);
        chk("s_rready", s_rready, e_rr);
        chk("s_arvalid", s_arvalid, m_arvld);
        chk("s_araddr", s_araddr, m_addr);
        chk("s_arid", s_arid, m_id);
        chk("s_arlen", s_arlen, m_len);
        chk("rid_err", rid_err, m_rid_err);
        chk("rdata_pass", d_rdata, s_rdata);
        last_ar = ar_rdy; last_rv = d_rvalid; last_rr = s_rready;
        @(posedge clk);
`ifdef SA_RID_CHECK_EN
        if (hs && s_rid != oq[0].id) m_rid_err = 1;
`endif
        if (hs && s_rlast) void'(oq.pop_front());
        if (acc) begin
            oq.push_back('{mst: g, id: ar_id[g*5 +: 5]});
            m_arvld = 1;
            m_id    = ar_id[g*5 +: 5];
            m_addr  = ar_addr[g*32 +: 32];
            m_len   = ar_len[g*3 +: 3];
            m_prio  = (g + 1) % 2;
        end else if (s_arready) begin
            m_arvld = 0;
        end
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        model_reset();
        @(posedge clk); #1;
        chk("rst_arvalid", s_arvalid, 1'b0);
        chk("rst_araddr", s_araddr, 32'h0);
        chk("rst_arready", ar_rdy, 2'b00);
        chk("rst_rid_err", rid_err, 1'b0);
        rst = 0;
    endtask

    task automatic drain();
        int budget = 300;
        ar_vld = '0;
        s_arready = 1;
        while (oq.size() > 0 && budget > 0) begin
            s_rvalid = 1; r_rdy = 2'b11; s_rid = oq[0].id;
            s_rlast = ($urandom % 2) == 0; s_rdata = $urandom;
            step();
            budget--;
        end
        chk("drain_done", oq.size(), 0);
        s_rvalid = 0; s_rlast = 0;
    endtask

    int acc_cnt;
    logic [1:0] got[4];

    initial begin
        clear_inputs();
        model_reset();
        rst = 1;
        #1;
        do_reset();

        // Single burst from master 0
        set_req(0, 1, 5'd3, 32'h4000_0010, 3'd3);
        s_arready = 1;
        step();
        chk("t1_grant", last_ar, 2'b01);
        ar_vld = '0;
        chk("t1_arvalid_next", s_arvalid, 1'b1);
        chk("t1_araddr", s_araddr, 32'h4000_0010);
        for (int b = 0; b < 4; b++) begin
            s_rvalid = 1; r_rdy = 2'b11; s_rid = 5'd3; s_rlast = (b == 3); s_rdata = $urandom;
            step();
            chk("t1_beat_route", last_rv, 2'b01);
        end
        s_rlast = 0;
        step();
        chk("t1_empty_after_last", last_rv, 2'b00);
        s_rvalid = 0;

        // Round-robin between two persistent requesters
        do_reset();
        s_arready = 1;
        set_req(0, 1, 5'd1, 32'h100, 3'd0);
        set_req(1, 1, 5'd2, 32'h200, 3'd0);
        for (int k = 0; k < 4; k++) begin
            step();
            got[k] = last_ar;
        end
        chk("rr_0", got[0], 2'b01);
        chk("rr_1", got[1], 2'b10);
        chk("rr_2", got[2], 2'b01);
        chk("rr_3", got[3], 2'b10);
        drain();

        // FIFO fill: 8 accepts then stall; a pop frees a slot one cycle later
        do_reset();
        s_arready = 1;
        acc_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            set_req(1, 1, 5'($urandom % 8), $urandom, 3'($urandom));
            step();
            if (last_ar != 2'b00) acc_cnt++;
        end
        chk("full_accepts", acc_cnt, 8);
        s_rvalid = 1; s_rlast = 1; r_rdy = 2'b10; s_rid = oq[0].id;
        step();
        chk("pop_cycle_no_grant", last_ar, 2'b00);
        s_rvalid = 0; s_rlast = 0;
        step();
        chk("post_pop_grant", last_ar, 2'b10);
        drain();

        // Head-of-line hold: master 1 not ready, master 0 burst behind it
        do_reset();
        s_arready = 1;
        set_req(1, 1, 5'd1, 32'h1111, 3'd0);
        step();
        ar_vld = '0;
        set_req(0, 1, 5'd2, 32'h2222, 3'd0);
        step();
        ar_vld = '0; s_arready = 0;
        s_rvalid = 1; s_rlast = 1; s_rid = 5'd1; r_rdy = 2'b01;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("hold_rready", last_rr, 1'b0);
            chk("hold_rvalid", last_rv, 2'b10);
        end

        // Asynchronous reset with two bursts outstanding and AR held
        chk("pre_rst_arvalid", s_arvalid, 1'b1);
        r_rdy = 2'b11; ar_vld = 2'b11;
        #2 rst = 1;
        #1;
        chk("async_rst_arvalid", s_arvalid, 1'b0);
        chk("async_rst_rready", s_rready, 1'b0);
        chk("async_rst_rvalid", d_rvalid, 2'b00);
        chk("async_rst_arready", ar_rdy, 2'b00);
        model_reset();
        @(posedge clk); #1;
        rst = 0; ar_vld = '0;
        step();
        chk("post_rst_no_route", last_rv, 2'b00);
        s_rvalid = 0; s_rlast = 0;

        // RID mismatch
        do_reset();
        s_arready = 1;
        set_req(0, 1, 5'd3, 32'h3000, 3'd0);
        step();
        ar_vld = '0;
        s_rvalid = 1; s_rlast = 1; s_rid = 5'd5; r_rdy = 2'b01;
        step();
        s_rvalid = 0;
`ifdef SA_RID_CHECK_EN
        chk("rid_err_set", rid_err, 1'b1);
`else
        chk("rid_err_tied", rid_err, 1'b0);
`endif
        step();
        step();

        // Random traffic
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (k == 300) do_reset();
            for (int m = 0; m < 2; m++)
                set_req(m, ($urandom % 3) != 0, 5'($urandom % 8), $urandom, 3'($urandom));
            s_arready = ($urandom % 4) != 0;
            s_rvalid  = ($urandom % 2) == 0;
            s_rlast   = ($urandom % 3) == 0;
            r_rdy     = 2'($urandom);
            s_rdata   = $urandom;
            s_rid     = (oq.size() > 0 && ($urandom % 8) != 0) ? oq[0].id : 5'($urandom % 8);
            step();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
